// File: rtl/alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the TMR ALU front-end scheduler:
//   - scheduler FSM state encoding
//   - frame geometry (35-bit {OPCODE, B, A}) and field offsets
//   - build_frame() helper that packs a request into a serial frame
// No ports (package).
// -----------------------------------------------------------------------------
package alu_sched_pkg;

  localparam int FRAME_BITS = 35;
  localparam int OPCODE_W   = 3;
  localparam int DATA_W     = 16;
  localparam int MUL_W      = 15;

  // Frame field offsets, LSB first on the wire
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 16;
  localparam int OP_LSB = 32;

  // Shift counter runs 0..FRAME_BITS-1
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Pack one request into the serial frame layout seen by the ALU loader
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [OPCODE_W-1:0] op,
    input logic [DATA_W-1:0]   b,
    input logic [DATA_W-1:0]   a
  );
    logic [FRAME_BITS-1:0] f;
    f                    = {FRAME_BITS{1'b0}};
    f[A_LSB  +: DATA_W]  = a;
    f[B_LSB  +: DATA_W]  = b;
    f[OP_LSB +: OPCODE_W] = op;
    return f;
  endfunction

endpackage

// File: rtl/alu_tmr_scheduler_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the request
// lines and the registered 'last' pointer; the pointer moves to the granted
// index whenever the grant is actually taken by the consumer.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_req0/1       request lines
//   i_take         consumer accepts the current grant this cycle
//   o_gnt_valid    at least one request present
//   o_gnt_id       index of the granted requester
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  // Index of the most recent grant; resets to 1 so requester 0 wins the first tie
  logic r_last;

  // Grant selection: on a tie favour the requester that was not served last
  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_id = ~r_last;
    end else if (i_req1) begin
      o_gnt_id = 1'b1;
    end else begin
      o_gnt_id = 1'b0;
    end
  end

  // Round-robin pointer update on every taken grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_take && o_gnt_valid) begin
      r_last <= o_gnt_id;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/alu_tmr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_tmr_scheduler
// Front-end controller for the triple-redundant ALU. Arbitrates two requesters,
// serialises the winning {OPCODE, B, A} frame LSB first onto the ALU loader
// (ALU_DATA + ALU_START), waits RES_WAIT cycles for the voted result to settle,
// captures it and returns it with the requester ID as a one-cycle strobe.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   REQn_VALID/OPCODE/A/B         request n (n = 0, 1)
//   REQn_READY                    one-cycle accept pulse (IDLE only)
//   ALU_DATA, ALU_START           serial frame bit and frame strobe to the ALU
//   ALU_OUT, ALU_OUT_2, ALU_COUT  voted ALU results
//   RSP_VALID, RSP_ID             response strobe and requester index
//   RSP_RESULT, RSP_MUL, RSP_COUT captured results, held until next capture
//   BUSY                          high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_tmr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int RES_WAIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ0_VALID,
  input  logic [OPCODE_W-1:0] REQ0_OPCODE,
  input  logic [DATA_W-1:0]   REQ0_A,
  input  logic [DATA_W-1:0]   REQ0_B,
  output logic                REQ0_READY,
  input  logic                REQ1_VALID,
  input  logic [OPCODE_W-1:0] REQ1_OPCODE,
  input  logic [DATA_W-1:0]   REQ1_A,
  input  logic [DATA_W-1:0]   REQ1_B,
  output logic                REQ1_READY,
  output logic                ALU_DATA,
  output logic                ALU_START,
  input  logic [DATA_W-1:0]   ALU_OUT,
  input  logic [MUL_W-1:0]    ALU_OUT_2,
  input  logic                ALU_COUT,
  output logic                RSP_VALID,
  output logic                RSP_ID,
  output logic [DATA_W-1:0]   RSP_RESULT,
  output logic [MUL_W-1:0]    RSP_MUL,
  output logic                RSP_COUT,
  output logic                BUSY
);

  localparam int WAIT_W = (RES_WAIT > 1) ? $clog2(RES_WAIT) : 1;

  sched_state_e          r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_gnt_id;
  logic                  r_alu_data;
  logic                  r_alu_start;
  logic                  r_busy;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [DATA_W-1:0]     r_rsp_result;
  logic [MUL_W-1:0]      r_rsp_mul;
  logic                  r_rsp_cout;

  logic                  w_gnt_valid;
  logic                  w_gnt_id;
  logic                  w_take;
  logic                  w_grant;
  logic [OPCODE_W-1:0]   w_op;
  logic [DATA_W-1:0]     w_a;
  logic [DATA_W-1:0]     w_b;
  logic [FRAME_BITS-1:0] w_frame;

  // Grants are only taken in IDLE and never while reset is applied
  assign w_take  = (r_state == ST_IDLE) & ~RST;
  assign w_grant = w_take & w_gnt_valid;

  rr_arb2 u_arb (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_req0      (REQ0_VALID),
    .i_req1      (REQ1_VALID),
    .i_take      (w_take),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // Operand mux: select the granted requester's fields
  always_comb begin
    if (w_gnt_id) begin
      w_op = REQ1_OPCODE;
      w_a  = REQ1_A;
      w_b  = REQ1_B;
    end else begin
      w_op = REQ0_OPCODE;
      w_a  = REQ0_A;
      w_b  = REQ0_B;
    end
  end

  assign w_frame = build_frame(w_op, w_b, w_a);

  // Scheduler FSM with registered loader, busy and response outputs.
  // On accept, frame bit 0 is presented directly and the remaining bits are
  // stored pre-shifted, so ALU_DATA shows bit k in SHIFT cycle k.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= {CNT_W{1'b0}};
      r_wait_cnt   <= {WAIT_W{1'b0}};
      r_shift      <= {FRAME_BITS{1'b0}};
      r_gnt_id     <= 1'b0;
      r_alu_data   <= 1'b0;
      r_alu_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= {DATA_W{1'b0}};
      r_rsp_mul    <= {MUL_W{1'b0}};
      r_rsp_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state     <= ST_SHIFT;
            r_gnt_id    <= w_gnt_id;
            r_shift     <= {1'b0, w_frame[FRAME_BITS-1:1]};
            r_alu_data  <= w_frame[0];
            r_alu_start <= 1'b1;
            r_busy      <= 1'b1;
            r_bit_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            r_state     <= ST_WAIT;
            r_alu_start <= 1'b0;
            r_alu_data  <= 1'b0;
            r_wait_cnt  <= {WAIT_W{1'b0}};
          end else begin
            r_bit_cnt  <= r_bit_cnt + 6'd1;
            r_alu_data <= r_shift[0];
            r_shift    <= {1'b0, r_shift[FRAME_BITS-1:1]};
          end
        end

        ST_WAIT: begin
          if (r_wait_cnt == WAIT_W'(RES_WAIT - 1)) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_gnt_id;
            r_rsp_result <= ALU_OUT;
            r_rsp_mul    <= ALU_OUT_2;
            r_rsp_cout   <= ALU_COUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_alu_start <= 1'b0;
          r_alu_data  <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign REQ0_READY = w_grant & ~w_gnt_id;
  assign REQ1_READY = w_grant &  w_gnt_id;
  assign ALU_DATA   = r_alu_data;
  assign ALU_START  = r_alu_start;
  assign BUSY       = r_busy;
  assign RSP_VALID  = r_rsp_valid;
  assign RSP_ID     = r_rsp_id;
  assign RSP_RESULT = r_rsp_result;
  assign RSP_MUL    = r_rsp_mul;
  assign RSP_COUT   = r_rsp_cout;

endmodule

// File: tb/tb_alu_tmr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_tmr_scheduler
// Self-checking bench for alu_tmr_scheduler. A behavioural ALU stand-in
// deserialises the loader stream and drives results; expected responses are
// computed from the requested operands directly.
// -----------------------------------------------------------------------------
module tb_alu_tmr_scheduler;

  localparam int RES_WAIT = 4;
  localparam int LATENCY  = 36 + RES_WAIT;   // accept cycle -> response cycle
  localparam int PERIOD   = 37 + RES_WAIT;   // accept -> next possible accept

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic [2:0]  REQ0_OPCODE, REQ1_OPCODE;
  logic [15:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic        REQ0_READY, REQ1_READY;
  logic        ALU_DATA, ALU_START;
  logic [15:0] ALU_OUT;
  logic [14:0] ALU_OUT_2;
  logic        ALU_COUT;
  logic        RSP_VALID, RSP_ID, RSP_COUT, BUSY;
  logic [15:0] RSP_RESULT;
  logic [14:0] RSP_MUL;

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;
  bit model_last;
  logic [2:0]  op_q [2];
  logic [15:0] a_q  [2];
  logic [15:0] b_q  [2];
  logic [34:0] alu_sh = 35'd0;

  alu_tmr_scheduler #(.RES_WAIT(RES_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_OPCODE(REQ0_OPCODE), .REQ0_A(REQ0_A),
    .REQ0_B(REQ0_B), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_OPCODE(REQ1_OPCODE), .REQ1_A(REQ1_A),
    .REQ1_B(REQ1_B), .REQ1_READY(REQ1_READY),
    .ALU_DATA(ALU_DATA), .ALU_START(ALU_START),
    .ALU_OUT(ALU_OUT), .ALU_OUT_2(ALU_OUT_2), .ALU_COUT(ALU_COUT),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RESULT(RSP_RESULT),
    .RSP_MUL(RSP_MUL), .RSP_COUT(RSP_COUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference ALU behaviour
  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [14:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = a * b;
    return p[14:0];
  endfunction

  function automatic logic ref_cout(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16];
  endfunction

  // ALU stand-in: collect the serial frame while the strobe is high
  always @(posedge CLK) begin
    if (ALU_START) alu_sh <= {ALU_DATA, alu_sh[34:1]};
  end

  always_comb begin
    ALU_OUT   = ref_res(alu_sh[34:32], alu_sh[15:0], alu_sh[31:16]);
    ALU_OUT_2 = ref_mul(alu_sh[15:0], alu_sh[31:16]);
    ALU_COUT  = ref_cout(alu_sh[15:0], alu_sh[31:16]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    op_q[id] = op; a_q[id] = a; b_q[id] = b;
    if (id == 0) begin
      REQ0_VALID = v; REQ0_OPCODE = op; REQ0_A = a; REQ0_B = b;
    end else begin
      REQ1_VALID = v; REQ1_OPCODE = op; REQ1_A = a; REQ1_B = b;
    end
  endtask

  task automatic set_valid(input int id, input logic v);
    if (id == 0) REQ0_VALID = v; else REQ1_VALID = v;
  endtask

  // Follow one operation from its accept cycle (called at that cycle's negedge)
  // to the IDLE cycle after the response. resp_action: 0 none, 1 drop all
  // requests in RESP, 2 raise the other requester in RESP.
  task automatic expect_op(input int id, input bit keep, input int resp_action,
                           input bit change_a, output int resp_cyc);
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [34:0] fr, rx;
    bit ok_start, ok_busy, ok_rdy, ok_wait;
    int t_acc;
    op = op_q[id]; a = a_q[id]; b = b_q[id];
    fr = {op, b, a};
    rx = 35'd0;
    ok_start = 1'b1; ok_busy = 1'b1; ok_rdy = 1'b1; ok_wait = 1'b1;
    #1;
    t_acc = cyc;
    check("ready_winner", (id == 0) ? REQ0_READY : REQ1_READY, 1);
    check("ready_other",  (id == 0) ? REQ1_READY : REQ0_READY, 0);
    check("busy_at_accept", BUSY, 0);
    model_last = (id != 0);
    @(negedge CLK);
    if (!keep) set_valid(id, 1'b0);
    for (int k = 0; k < 35; k++) begin
      if (change_a && k == 4) begin
        if (id == 0) REQ0_A = 16'hFFFF; else REQ1_A = 16'hFFFF;
      end
      rx[k] = ALU_DATA;
      ok_start &= (ALU_START === 1'b1);
      ok_busy  &= (BUSY === 1'b1);
      ok_rdy   &= (REQ0_READY === 1'b0) && (REQ1_READY === 1'b0);
      @(negedge CLK);
    end
    check("frame_bits", rx, fr);
    check("start_in_shift", ok_start, 1);
    check("busy_in_shift", ok_busy, 1);
    for (int w = 0; w < RES_WAIT; w++) begin
      ok_wait &= (ALU_START === 1'b0) && (ALU_DATA === 1'b0) && (RSP_VALID === 1'b0) && (BUSY === 1'b1);
      ok_rdy  &= (REQ0_READY === 1'b0) && (REQ1_READY === 1'b0);
      @(negedge CLK);
    end
    check("wait_quiet", ok_wait, 1);
    resp_cyc = cyc;
    check("rsp_valid", RSP_VALID, 1);
    check("rsp_latency", resp_cyc - t_acc, LATENCY);
    check("rsp_id", RSP_ID, id);
    check("rsp_result", RSP_RESULT, ref_res(op, a, b));
    check("rsp_mul", RSP_MUL, ref_mul(a, b));
    check("rsp_cout", RSP_COUT, ref_cout(a, b));
    ok_rdy &= (REQ0_READY === 1'b0) && (REQ1_READY === 1'b0);
    if (resp_action == 1) begin
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    end else if (resp_action == 2) begin
      set_req(1 - id, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      #1;
      ok_rdy &= (REQ0_READY === 1'b0) && (REQ1_READY === 1'b0);
    end
    check("no_ready_when_busy", ok_rdy, 1);
    @(negedge CLK);
    check("rsp_valid_drop", RSP_VALID, 0);
    check("busy_drop", BUSY, 0);
    check("rsp_hold", {RSP_ID, RSP_COUT, RSP_MUL, RSP_RESULT},
          {id[0], ref_cout(a, b), ref_mul(a, b), ref_res(op, a, b)});
  endtask

  initial begin
    int t0, t1, t2, id;
    bit v0, v1, quiet;
    RST = 1'b1;
    set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
    set_req(1, 1'b0, 3'd0, 16'd0, 16'd0);
    model_last = 1'b1;
    #1;
    check("reset_outputs", {ALU_START, ALU_DATA, RSP_VALID, RSP_ID, RSP_COUT, BUSY}, 0);
    check("reset_rsp_data", {RSP_MUL, RSP_RESULT}, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_no_ready", {REQ0_READY, REQ1_READY}, 0);

    // Single request with the reference operands
    set_req(0, 1'b1, 3'b001, 16'h0005, 16'h0003);
    expect_op(0, 1'b0, 0, 1'b0, t0);
    check("single_result_const", RSP_RESULT, 16'h0008);

    // Multiplier and carry capture through requester 1
    set_req(1, 1'b1, 3'b001, 16'hFFFF, 16'h0001);
    expect_op(1, 1'b0, 0, 1'b0, t0);
    repeat (3) @(negedge CLK);
    check("mul_carry_hold", {RSP_COUT, RSP_MUL}, {1'b1, 15'h7FFF});

    // Operand change after accept must not reach the frame
    set_req(0, 1'b1, 3'b001, 16'h0005, 16'h0003);
    expect_op(0, 1'b0, 0, 1'b1, t0);

    // Late arrival of requester 1 in the RESP cycle
    set_req(0, 1'b1, 3'd3, 16'h1234, 16'h00FF);
    expect_op(0, 1'b0, 2, 1'b0, t0);
    expect_op(1, 1'b0, 0, 1'b0, t1);
    quiet = 1'b1;
    repeat (5) begin
      quiet &= (REQ0_READY === 1'b0) && (REQ1_READY === 1'b0) && (BUSY === 1'b0);
      @(negedge CLK);
    end
    check("late_no_duplicate", quiet, 1);

    // Randomised requests, including ties
    for (int i = 0; i < 6; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      set_req(0, v0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      set_req(1, v1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      if (v0 && v1) id = model_last ? 0 : 1;
      else id = v1 ? 1 : 0;
      expect_op(id, 1'b0, 1, 1'b0, t0);
    end

    // Reset in the middle of SHIFT (bit 10)
    set_req(0, 1'b1, 3'd1, 16'hABCD, 16'h1111);
    #1;
    check("rst_test_accept", REQ0_READY, 1);
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    check("rst_test_in_shift", ALU_START, 1);
    RST = 1'b1;
    #1;
    check("rst_async_start", ALU_START, 0);
    check("rst_async_busy", BUSY, 0);
    check("rst_async_rsp", {RSP_VALID, RSP_ID, RSP_COUT, RSP_MUL, RSP_RESULT, ALU_DATA}, 0);
    @(negedge CLK);
    RST = 1'b0;
    model_last = 1'b1;
    quiet = 1'b1;
    repeat (60) begin
      quiet &= (RSP_VALID === 1'b0) && (ALU_START === 1'b0) && (BUSY === 1'b0);
      @(negedge CLK);
    end
    check("rst_abandons_frame", quiet, 1);

    // Tie after reset: continuous requests from both sides
    set_req(0, 1'b1, 3'd2, 16'h0100, 16'h0001);
    set_req(1, 1'b1, 3'd4, 16'h00F0, 16'h000F);
    id = model_last ? 0 : 1;
    check("tie_first_is_req0", id, 0);
    expect_op(id, 1'b1, 0, 1'b0, t0);
    id = model_last ? 0 : 1;
    expect_op(id, 1'b1, 0, 1'b0, t1);
    id = model_last ? 0 : 1;
    expect_op(id, 1'b1, 1, 1'b0, t2);
    check("tie_spacing_1", t1 - t0, PERIOD);
    check("tie_spacing_2", t2 - t1, PERIOD);
    #1;
    check("tie_done_idle", {REQ0_READY, REQ1_READY, BUSY}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
